// File: rtl/ling_sub_pipe_24.sv
// Three-stage pipelined Ling-prefix subtractor computing a - b - bin with valid/ready flow control.
// Define LING_SUB_OVF_EN to add the registered signed-overflow output ovf.
module ling_sub_pipe_24 #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef LING_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int BLK = 8;

    logic             s1_valid, s2_valid, s3_valid;
    logic             ready1, ready2, ready3;

    logic [WIDTH-1:0] s1_p, s1_g;
    logic             s1_cin;

    logic [WIDTH-1:0] s2_p, s2_g, s2_hl, s2_il;
    logic             s2_cin;

    logic [WIDTH-1:0] s3_diff;
    logic             s3_bout;

    logic [WIDTH-1:0] hl_next, il_next;
    logic [WIDTH-1:0] h_full, t, diff_next;
    logic [WIDTH:0]   c;
    logic             blk_h;
    logic             bout_next;

    // A stage may load when it is empty or its contents move on this cycle.
    assign ready3    = !s3_valid || out_ready;
    assign ready2    = !s2_valid || ready3;
    assign ready1    = !s1_valid || ready2;
    assign in_ready  = ready1 && !rst;
    assign out_valid = s3_valid;
    assign diff      = s3_diff;
    assign bout      = s3_bout;

    // Block-local Ling terms: hl is H within the 8-bit block, il is the propagate chain
    // that carries the previous block's H into this bit.
    always_comb begin
        hl_next    = '0;
        il_next    = '0;
        hl_next[0] = s1_g[0] | s1_cin;
        il_next[0] = 1'b0;
        for (int k = 1; k < WIDTH; k++) begin
            if ((k % BLK) == 0) begin
                hl_next[k] = s1_g[k];
                il_next[k] = s1_p[k-1];
            end else begin
                hl_next[k] = s1_g[k] | (s1_p[k-1] & hl_next[k-1]);
                il_next[k] = s1_p[k-1] & il_next[k-1];
            end
        end
    end

    // Resolve full H across blocks, then recover real carries as c[k+1] = p[k] & H[k].
    always_comb begin
        h_full = '0;
        c      = '0;
        blk_h  = 1'b0;
        c[0]   = s2_cin;
        for (int k = 0; k < WIDTH; k++) begin
            h_full[k] = s2_hl[k] | (s2_il[k] & blk_h);
            c[k+1]    = s2_p[k] & h_full[k];
            if ((k % BLK) == BLK - 1) begin
                blk_h = h_full[k];
            end
        end
        t         = s2_p ^ s2_g;
        diff_next = t ^ c[WIDTH-1:0];
        bout_next = ~c[WIDTH];
    end

`ifdef LING_SUB_OVF_EN
    logic s3_ovf;
    logic ovf_next;

    assign ovf_next = c[WIDTH] ^ c[WIDTH-1];
    assign ovf      = s3_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_ovf <= 1'b0;
        end else if (ready3 && s2_valid) begin
            s3_ovf <= ovf_next;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_cin   <= 1'b0;
            s2_valid <= 1'b0;
            s2_p     <= '0;
            s2_g     <= '0;
            s2_hl    <= '0;
            s2_il    <= '0;
            s2_cin   <= 1'b0;
            s3_valid <= 1'b0;
            s3_diff  <= '0;
            s3_bout  <= 1'b0;
        end else begin
            if (ready1) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_p   <= a | ~b;
                    s1_g   <= a & ~b;
                    s1_cin <= ~bin;
                end
            end
            if (ready2) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_p   <= s1_p;
                    s2_g   <= s1_g;
                    s2_hl  <= hl_next;
                    s2_il  <= il_next;
                    s2_cin <= s1_cin;
                end
            end
            if (ready3) begin
                s3_valid <= s2_valid;
                if (s2_valid) begin
                    s3_diff <= diff_next;
                    s3_bout <= bout_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_ling_sub_pipe_24.sv
// Self-checking bench for ling_sub_pipe_24: directed cases, backpressure, mid-stream reset
// and a random valid/ready regression scored against an arithmetic reference model.
module tb_ling_sub_pipe_24;

    localparam int W = 24;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
`ifdef LING_SUB_OVF_EN
    logic         ovf;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;
    int n_received   = 0;

    logic [W+1:0] exp_q[$];
    logic         held_valid;
    logic [W-1:0] held_diff;
    logic         held_bout;

    always #5 clk = ~clk;

    ling_sub_pipe_24 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef LING_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // Reference result packed as {ovf, bout, diff}, from plain wide integer arithmetic.
    function automatic logic [W+1:0] refModel(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic bi);
        longint ur, sr, lim;
        logic [W-1:0] d;
        logic bo, ov;
        ur  = longint'(x) - longint'(y) - longint'(bi);
        sr  = longint'($signed(x)) - longint'($signed(y)) - longint'(bi);
        lim = longint'(1) <<< (W - 1);
        bo  = (ur < 0);
        d   = ur[W-1:0];
        ov  = (sr < -lim) || (sr > lim - 1);
        return {ov, bo, d};
    endfunction

    function automatic logic [W-1:0] randOperand();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = '1;
            2:       v = {1'b1, {(W-1){1'b0}}};
            3:       v = {1'b0, {(W-1){1'b1}}};
            4:       v = W'($urandom_range(0, 3));
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive, score any result leaving this cycle, record any accepted beat.
    task automatic applyStimulus(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic ibin, input logic ordy,
                                 output logic accepted, output logic rdy);
        logic [W+1:0] e;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        bin       = ibin;
        out_ready = ordy;
        #1;
        if (held_valid && out_valid) begin
            checkOutput("hold_diff", 64'(diff), 64'(held_diff));
            checkOutput("hold_bout", 64'(bout), 64'(held_bout));
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_result", 64'(out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("sb_diff", 64'(diff), 64'(e[W-1:0]));
                checkOutput("sb_bout", 64'(bout), 64'(e[W]));
`ifdef LING_SUB_OVF_EN
                checkOutput("sb_ovf", 64'(ovf), 64'(e[W+1]));
`endif
                n_received++;
            end
        end
        held_valid = out_valid && !out_ready;
        held_diff  = diff;
        held_bout  = bout;
        rdy        = in_ready;
        accepted   = iv && in_ready;
        if (accepted) exp_q.push_back(refModel(ia, ib, ibin));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic runDirected(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                               input logic ibin, input logic [W-1:0] ed, input logic eb,
                               input logic eo);
        logic acc, rdy;
        int lat;
        applyStimulus(1'b1, ia, ib, ibin, 1'b1, acc, rdy);
        checkOutput({tag, "_accepted"}, 64'(acc), 64'd1);
        lat = 1;
        while (!out_valid && lat < 10) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, acc, rdy);
            lat++;
        end
        checkOutput({tag, "_latency"}, 64'(lat), 64'd3);
        checkOutput({tag, "_diff"}, 64'(diff), 64'(ed));
        checkOutput({tag, "_bout"}, 64'(bout), 64'(eb));
`ifdef LING_SUB_OVF_EN
        checkOutput({tag, "_ovf"}, 64'(ovf), 64'(eo));
`else
        if (eo === 1'bx) $display("[TB] note: unexpected x in ovf expectation for %s", tag);
`endif
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, acc, rdy);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic acc, rdy;
        logic [W-1:0] ra[10], rb[10];
        logic rbin[10];
        int idx, cyc, base, guard, accepted_n;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
        held_valid = 1'b0;

        @(negedge clk);
        #1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("post_rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("post_rst_diff", 64'(diff), 64'd0);
        checkOutput("post_rst_bout", 64'(bout), 64'd0);
`ifdef LING_SUB_OVF_EN
        checkOutput("post_rst_ovf", 64'(ovf), 64'd0);
`endif
        @(negedge clk);

        runDirected("d5m3", 24'h000005, 24'h000003, 1'b0, 24'h000002, 1'b0, 1'b0);
        runDirected("d0m1", 24'h000000, 24'h000001, 1'b0, 24'hFFFFFF, 1'b1, 1'b0);
        runDirected("d0m0b", 24'h000000, 24'h000000, 1'b1, 24'hFFFFFF, 1'b1, 1'b0);
        runDirected("dovf_neg", 24'h800000, 24'h000001, 1'b0, 24'h7FFFFF, 1'b0, 1'b1);
        runDirected("dovf_pos", 24'h7FFFFF, 24'hFFFFFF, 1'b0, 24'h800000, 1'b1, 1'b1);

        // Backpressure: continuous beats, downstream stalled for the first five cycles.
        for (int i = 0; i < 10; i++) begin
            ra[i] = randOperand(); rb[i] = randOperand(); rbin[i] = 1'($urandom_range(0, 1));
        end
        base = n_received; idx = 0; cyc = 0;
        while (idx < 10 && cyc < 60) begin
            applyStimulus(1'b1, ra[idx], rb[idx], rbin[idx], (cyc >= 5), acc, rdy);
            if (cyc < 5) checkOutput("bp_in_ready", 64'(rdy), 64'(idx < 3));
            if (acc) idx++;
            cyc++;
        end
        checkOutput("bp_all_accepted", 64'(idx), 64'd10);
        guard = 0;
        while (exp_q.size() > 0 && guard < 50) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, acc, rdy);
            guard++;
        end
        checkOutput("bp_received", 64'(n_received - base), 64'd10);
        checkOutput("bp_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset with two beats in flight and the head result stalled at the output.
        applyStimulus(1'b1, 24'h123456, 24'h000111, 1'b0, 1'b0, acc, rdy);
        applyStimulus(1'b1, 24'h000010, 24'h000020, 1'b1, 1'b0, acc, rdy);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, acc, rdy);
        checkOutput("pre_rst_out_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("async_rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        held_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, acc, rdy);
            checkOutput("post_rst_no_stale", 64'(out_valid), 64'd0);
        end
        runDirected("after_rst", 24'h00ABCD, 24'h00ABCE, 1'b0, 24'hFFFFFF, 1'b1, 1'b0);

        // Random regression with random in_valid/out_ready.
        accepted_n = 0; cyc = 0;
        while (accepted_n < 3000 && cyc < 40000) begin
            applyStimulus(($urandom_range(0, 3) != 0), randOperand(), randOperand(),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), acc, rdy);
            if (acc) accepted_n++;
            cyc++;
        end
        checkOutput("rand_accepted", 64'(accepted_n), 64'd3000);
        guard = 0;
        while (exp_q.size() > 0 && guard < 50) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, acc, rdy);
            guard++;
        end
        checkOutput("rand_drained", 64'(exp_q.size()), 64'd0);
        checkOutput("rand_idle_out_valid", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/ling_sub_pipe_24.md
LING_SUB_PIPE_24 -- requirements
Module: ling_sub_pipe_24

Interface
REQ-001 Parameter: WIDTH, 24, operand/result width; even values >= 4 only.
REQ-002 Port: clk  input  1  sole clock; all state on rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous and active-high.
REQ-004 Port: in_valid  input  1  operand beat valid.
REQ-005 Port: in_ready  output  1  block accepts beat this cycle.
REQ-006 Port: a  input  WIDTH  minuend.
REQ-007 Port: b  input  WIDTH  subtrahend.
REQ-008 Port: bin  input  1  borrow-in.
REQ-009 Port: out_valid  output  1  result beat valid.
REQ-010 Port: out_ready  input  1  downstream accepts result.
REQ-011 Port: diff  output  WIDTH  (a - b - bin) mod 2^WIDTH.
REQ-012 Port: bout  output  1  borrow-out; 1 iff unsigned a < b + bin.
REQ-013 Port: ovf  output  1  signed overflow; present only per REQ-027.

Function
REQ-014 The datapath SHALL add a, ~b and carry-in ~bin using the team's Ling prefix structure: pre-compute p = a|~b, g = a&~b; form H/I group terms; c[k+1] = p[k] & H[k:0]; bout = ~cout.
REQ-015 Pipeline SHALL have three register stages:
- S1 captures p, g and ~bin.
- S2 captures H/I terms spanning 8 bits and the prefix-tree intermediates.
- S3 captures diff, bout and ovf.
REQ-016 Latency SHALL be exactly 3 cycles from an accepted beat to out_valid=1 when out_ready is held 1.
REQ-017 A beat SHALL be accepted on a clk edge iff in_valid=1 and in_ready=1; transfer out SHALL occur iff out_valid=1 and out_ready=1.
REQ-018 Each stage SHALL advance when the next stage is empty or advancing; in_ready = !S1_valid | S1 advancing (combinational back-propagation; no bubbles when out_ready=1).
REQ-019 Full throughput SHALL be 1 beat per cycle; capacity SHALL be 3 beats in flight.
REQ-020 While out_valid=1 and out_ready=0, diff, bout and ovf SHALL hold stable and no beat SHALL be lost or duplicated.
REQ-021 Simultaneous accept at S1 and drain at S3 in one cycle SHALL both take effect.
REQ-022 Beat order SHALL be preserved.
REQ-023 Data registers without valid SHALL NOT be observable: out_valid=0 qualifies diff/bout/ovf, which are then don't-care but reset-defined.

Reset
REQ-024 While rst=1, all stage valid bits SHALL be 0 and out_valid SHALL be 0, asynchronously; in_ready SHALL be 0.
REQ-025 After reset, diff, bout and ovf SHALL be 0; in_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight beats; no result SHALL emerge after release.

Configuration
REQ-027 Macro LING_SUB_OVF_EN:
- Defined: port ovf exists, registered in S3. ovf = 1 iff the signed result a - b - bin lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1], computed as carry-into-MSB XOR carry-out.
- Undefined: port ovf and its logic are absent; all other behaviour is unchanged.

Verification
REQ-028 a=0x000005, b=0x000003, bin=0, out_ready=1 -> after 3 cycles diff=0x000002, bout=0, ovf=0.
REQ-029 a=0x000000, b=0x000001, bin=0 -> diff=0xFFFFFF, bout=1; then a=0x000000, b=0x000000, bin=1 -> diff=0xFFFFFF, bout=1.
REQ-030 a=0x800000, b=0x000001, bin=0 with LING_SUB_OVF_EN -> diff=0x7FFFFF, bout=0, ovf=1; a=0x7FFFFF, b=0xFFFFFF -> diff=0x800000, bout=1, ovf=1.
REQ-031 Backpressure case:
- Stimulus: stream 10 random beats with in_valid=1 continuously; hold out_ready=0 for 5 cycles.
- Response: in_ready drops after 3 beats are held; all 10 results arrive in order and match the reference model; no beat is lost or duplicated.
REQ-032 Reset mid-stream:
- Stimulus: pulse rst for 1 cycle with 2 beats in flight.
- Response: out_valid=0 immediately; no stale result after release; the next beat completes with 3-cycle latency.
REQ-033 Randomised regression: 10^5 random beats with random in_valid/out_ready, checked against a - b - bin, for WIDTH=24 and WIDTH=8.
